// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline control path.
// Used by the hazard controller and by the ID/EX bubble logic.
package pipeline_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } hz_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [1:0] wb;
      logic [1:0] mem;
      logic [3:0] exe;
   } ctrl_word_t;

   // Control word that ID/EX consumers substitute when id_ex_flush is high.
   localparam ctrl_word_t NOP_CTRL = '0;

   // A load in EX feeds a source register of the instruction in ID; x0 never counts.
   function automatic logic load_use_hit(input logic       mem_read,
                                         input logic [4:0] rd,
                                         input logic [4:0] rs1,
                                         input logic [4:0] rs2);
      return mem_read && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/perf_counter_sat.sv
// Saturating up-counter with increment enable and synchronous clear.
// Holds at all-ones instead of wrapping.
module perf_counter_sat #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (clr)
         count_reg <= '0;
      else if (inc && (count_reg != {W{1'b1}}))
         count_reg <= count_reg + W'(1);
   end

   assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer: load-use bubbles, multi-cycle branch flush and
// data-memory freeze, plus stall-cycle and flush-event counters.
module pipeline_hazard_controller
   import pipeline_pkg::*;
#(
   parameter int BRANCH_PENALTY = 2,
   parameter int CNT_W          = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_ex_mem_read,
   input  logic [4:0]       id_ex_rd,
   input  logic [4:0]       if_id_rs1,
   input  logic [4:0]       if_id_rs2,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             pipe_hold,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   hz_state_t  state_reg, state_next;
   logic [2:0] fcnt_reg, fcnt_next;
   logic       mem_stall;
   logic       load_use;
   logic       flush_accept;
   logic [1:0] cnt_inc;
   logic [CNT_W-1:0] cnt_val [2];

   assign mem_stall = mem_req & ~mem_ready;
   assign load_use  = load_use_hit(id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= RUN;
         fcnt_reg  <= 3'd0;
      end else begin
         state_reg <= state_next;
         fcnt_reg  <= fcnt_next;
      end
   end

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      pipe_hold    = 1'b0;
      flush_accept = 1'b0;
      state_next   = state_reg;
      fcnt_next    = fcnt_reg;

      if (reset) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         state_next  = RUN;
         fcnt_next   = 3'd0;
      end else begin
         unique case (state_reg)
            RUN: begin
               if (mem_stall) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  pipe_hold   = 1'b1;
                  state_next  = MEM_WAIT;
               end else if (branch_taken) begin
                  if_id_flush  = 1'b1;
                  id_ex_flush  = 1'b1;
                  flush_accept = 1'b1;
                  if (BRANCH_PENALTY > 1) begin
                     state_next = FLUSH;
                     fcnt_next  = 3'(BRANCH_PENALTY - 1);
                  end
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end
            MEM_WAIT: begin
               // EX is frozen here, so a branch seen now is re-evaluated in RUN.
               if (!mem_ready) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  pipe_hold   = 1'b1;
               end else begin
                  state_next = RUN;
               end
            end
            FLUSH: begin
               if_id_flush = 1'b1;
               if (mem_stall) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  pipe_hold   = 1'b1;
               end else begin
                  fcnt_next = fcnt_reg - 3'd1;
                  if (fcnt_reg <= 3'd1)
                     state_next = RUN;
               end
            end
            default: begin
               state_next = RUN;
               fcnt_next  = 3'd0;
            end
         endcase
      end
   end

   assign cnt_inc[0] = ~reset & ~pc_write;
   assign cnt_inc[1] = flush_accept;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         perf_counter_sat #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .clr   (reset),
            .inc   (cnt_inc[gi]),
            .count (cnt_val[gi])
         );
      end
   endgenerate

   assign stall_cycles = cnt_val[0];
   assign flush_events = cnt_val[1];

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scoreboard bench for pipeline_hazard_controller: each step pushes the
// expected control vector and counter values, then pops and checks mid-cycle.
module tb_pipeline_hazard_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_ex_mem_read;
   logic [4:0]  id_ex_rd, if_id_rs1, if_id_rs2;
   logic        branch_taken, mem_req, mem_ready;
   logic        pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold;
   logic [31:0] stall_cycles, flush_events;
   logic [4:0]  ctrl_obs;

   typedef struct packed {
      logic [4:0]  ctrl;
      logic [31:0] sc;
      logic [31:0] fe;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   step_no  = 0;

   // {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}
   localparam logic [4:0] DEF = 5'b11000;
   localparam logic [4:0] RST = 5'b00110;
   localparam logic [4:0] LU  = 5'b00010;
   localparam logic [4:0] HLD = 5'b00001;
   localparam logic [4:0] BR  = 5'b11110;
   localparam logic [4:0] FL  = 5'b11100;
   localparam logic [4:0] FLH = 5'b00101;

   always #5 clk = ~clk;

   assign ctrl_obs = {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold};

   pipeline_hazard_controller #(.BRANCH_PENALTY(2), .CNT_W(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .id_ex_mem_read (id_ex_mem_read),
      .id_ex_rd       (id_ex_rd),
      .if_id_rs1      (if_id_rs1),
      .if_id_rs2      (if_id_rs2),
      .branch_taken   (branch_taken),
      .mem_req        (mem_req),
      .mem_ready      (mem_ready),
      .pc_write       (pc_write),
      .if_id_write    (if_id_write),
      .if_id_flush    (if_id_flush),
      .id_ex_flush    (id_ex_flush),
      .pipe_hold      (pipe_hold),
      .stall_cycles   (stall_cycles),
      .flush_events   (flush_events)
   );

   task automatic check_out();
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
         failures++;
         $error("FAIL scoreboard_empty step=%0d got=0 entries want>=1", step_no);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checks++;
         assert (ctrl_obs === e.ctrl) else begin
            failures++;
            $error("FAIL ctrl step=%0d got=%b want=%b", step_no, ctrl_obs, e.ctrl);
         end
         checks++;
         assert (stall_cycles === e.sc) else begin
            failures++;
            $error("FAIL stall_cycles step=%0d got=%0d want=%0d", step_no, stall_cycles, e.sc);
         end
         checks++;
         assert (flush_events === e.fe) else begin
            failures++;
            $error("FAIL flush_events step=%0d got=%0d want=%0d", step_no, flush_events, e.fe);
         end
      end
   endtask

   // Drive one cycle of inputs, record expectations, check at the falling edge.
   task automatic step(input logic r, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic br, input logic mq, input logic my,
                       input logic [4:0] ctrl, input int sc, input int fe);
      exp_t e;
      reset = r; id_ex_mem_read = mr; id_ex_rd = rd; if_id_rs1 = rs1; if_id_rs2 = rs2;
      branch_taken = br; mem_req = mq; mem_ready = my;
      e.ctrl = ctrl; e.sc = 32'(sc); e.fe = 32'(fe);
      sb.push_back(e);
      step_no++;
      @(negedge clk);
      check_out();
      $display("step %0d rst=%0b br=%0b mq=%0b my=%0b ctrl=%b stall=%0d flush=%0d",
               step_no, r, br, mq, my, ctrl_obs, stall_cycles, flush_events);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; id_ex_mem_read = 1'b0; id_ex_rd = '0; if_id_rs1 = '0; if_id_rs2 = '0;
      branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      //    r  mr rd    rs1   rs2   br mq my  ctrl sc  fe
      step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, RST, 0,  0);  // reset values
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, DEF, 0,  0);
      step(0, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0, LU,  0,  0);  // load-use via rs2
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, DEF, 1,  0);
      step(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, DEF, 1,  0);  // x0 never stalls
      step(0, 1, 5'd7, 5'd7, 5'd3, 0, 0, 0, LU,  1,  0);  // load-use via rs1
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, DEF, 2,  0);
      step(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, BR,  2,  0);  // taken branch
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, FL,  2,  1);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, DEF, 2,  1);
      step(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, BR,  2,  1);
      step(0, 1, 5'd4, 5'd4, 5'd4, 1, 0, 0, FL,  2,  2);  // branch/load-use ignored in FLUSH
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, DEF, 2,  2);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, HLD, 2,  2);  // memory wait, 3 cycles
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, HLD, 3,  2);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, HLD, 4,  2);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, DEF, 5,  2);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, DEF, 5,  2);
      step(0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, HLD, 5,  2);  // stall beats branch
      step(0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 1, DEF, 6,  2);
      step(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, BR,  6,  2);  // branch accepted in RUN
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, FLH, 6,  3);  // stall extends FLUSH
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, FLH, 7,  3);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, FL,  8,  3);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, DEF, 8,  3);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, HLD, 8,  3);  // reset mid MEM_WAIT
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, HLD, 9,  3);
      step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, RST, 10, 3);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, DEF, 0,  0);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, DEF, 0,  0);
      step(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, BR,  0,  0);  // reset mid FLUSH
      step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, RST, 0,  1);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, DEF, 0,  0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
